write_back_pipeline: RTL and testbench



---
 rtl/write_back_pipeline_pkg.sv | 31 +++
 rtl/write_back_pipeline_if.sv | 45 ++++
 rtl/write_back_pipeline_load_data_aligner.sv | 56 +++++
 rtl/write_back_pipeline.sv | 154 +++++++++++++++
 tb/tb_write_back_pipeline.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/write_back_pipeline_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : riscv_wb_pkg                                           |
// | Purpose : Shared encodings for the write-back stage: result      |
// |           source select, funct3 load types and FSM states.       |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package riscv_wb_pkg;

  // Result source select driven by the MEM stage
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_CSR  = 2'd3;

  // funct3 load encodings
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LD  = 3'b011;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
  localparam logic [2:0] LOAD_LWU = 3'b110;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/write_back_pipeline_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : write_back_pipeline_if                               |
// | Purpose   : MEM-stage inputs, data-cache return, flush, stall    |
// |             and register-file write port of the write-back stage.|
// | Rev       : 1.0  initial release                                 |
// +------------------------------------------------------------------+
interface write_back_pipeline_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int LOAD_TYPE_WIDTH = 3
);
  logic                       mem_valid_in;
  logic [DATA_WIDTH-1:0]      mem_alu_out_in;
  logic [DATA_WIDTH-1:0]      mem_pc_plus4_in;
  logic [DATA_WIDTH-1:0]      mem_csr_data_in;
  logic [REG_ADDR_WIDTH-1:0]  mem_rd_addr_in;
  logic                       mem_rd_write_in;
  logic [1:0]                 mem_wb_select_in;
  logic [LOAD_TYPE_WIDTH-1:0] mem_load_type_in;
  logic [DATA_WIDTH-1:0]      data_cache_out_data;
  logic                       data_cache_ready;
  logic                       flush_in;
  logic                       wb_stall_out;
  logic                       rf_write_en_out;
  logic [REG_ADDR_WIDTH-1:0]  rf_write_addr_out;
  logic [DATA_WIDTH-1:0]      rf_write_data_out;

  // Upstream pipeline / test driver side
  modport master (
    output mem_valid_in, mem_alu_out_in, mem_pc_plus4_in, mem_csr_data_in,
           mem_rd_addr_in, mem_rd_write_in, mem_wb_select_in, mem_load_type_in,
           data_cache_out_data, data_cache_ready, flush_in,
    input  wb_stall_out, rf_write_en_out, rf_write_addr_out, rf_write_data_out
  );

  // Write-back stage side
  modport slave (
    input  mem_valid_in, mem_alu_out_in, mem_pc_plus4_in, mem_csr_data_in,
           mem_rd_addr_in, mem_rd_write_in, mem_wb_select_in, mem_load_type_in,
           data_cache_out_data, data_cache_ready, flush_in,
    output wb_stall_out, rf_write_en_out, rf_write_addr_out, rf_write_data_out
  );
endinterface
`default_nettype wire

// File: rtl/write_back_pipeline_load_data_aligner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : load_data_aligner                                      |
// | Purpose : Picks the addressed byte/half/word out of an aligned   |
// |           read word and sign- or zero-extends it. Combinational. |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module load_data_aligner
  import riscv_wb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int LOAD_TYPE_WIDTH = 3,
  parameter int OFF_W           = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0]      raw_data,
  input  logic [OFF_W-1:0]           addr_lo,
  input  logic [LOAD_TYPE_WIDTH-1:0] load_type,
  output logic [DATA_WIDTH-1:0]      ext_data
);

  // Offsets rounded down to the access size; sub-size address bits are ignored
  logic [OFF_W-1:0]      half_off;
  logic [OFF_W-1:0]      word_off;
  logic [DATA_WIDTH-1:0] byte_shift;
  logic [DATA_WIDTH-1:0] half_shift;
  logic [DATA_WIDTH-1:0] word_shift;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [31:0]           word_val;

  assign half_off   = addr_lo & ~OFF_W'(1);
  assign word_off   = addr_lo & ~OFF_W'(3);
  assign byte_shift = raw_data >> {addr_lo, 3'b000};
  assign half_shift = raw_data >> {half_off, 3'b000};
  assign word_shift = raw_data >> {word_off, 3'b000};
  assign byte_val   = byte_shift[7:0];
  assign half_val   = half_shift[15:0];
  assign word_val   = word_shift[31:0];

  // Extend the selected field; on 32-bit the word cases reduce to the raw word
  always_comb begin
    ext_data = raw_data;
    case (load_type)
      LOAD_LB:  begin ext_data = {DATA_WIDTH{byte_val[7]}};  ext_data[7:0]  = byte_val; end
      LOAD_LBU: begin ext_data = '0;                          ext_data[7:0]  = byte_val; end
      LOAD_LH:  begin ext_data = {DATA_WIDTH{half_val[15]}}; ext_data[15:0] = half_val; end
      LOAD_LHU: begin ext_data = '0;                          ext_data[15:0] = half_val; end
      LOAD_LW:  begin ext_data = {DATA_WIDTH{word_val[31]}}; ext_data[31:0] = word_val; end
      LOAD_LWU: begin ext_data = '0;                          ext_data[31:0] = word_val; end
      LOAD_LD:  ext_data = raw_data;
      default:  ext_data = raw_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/write_back_pipeline.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : write_back_pipeline                                    |
// | Purpose : Registered write-back stage: result select, load       |
// |           alignment, cache-miss hold, flush and x0 suppression.  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module write_back_pipeline
  import riscv_wb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int LOAD_TYPE_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  write_back_pipeline_if.slave  bus
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  wb_state_t                  state, state_next;
  logic                       stall, retire, capture;

  logic [DATA_WIDTH-1:0]      cap_alu, cap_pc4, cap_csr;
  logic [REG_ADDR_WIDTH-1:0]  cap_rd;
  logic                       cap_rd_write;
  logic [1:0]                 cap_sel;
  logic [LOAD_TYPE_WIDTH-1:0] cap_ltype;

  logic [DATA_WIDTH-1:0]      src_alu, src_pc4, src_csr;
  logic [REG_ADDR_WIDTH-1:0]  src_rd;
  logic                       src_rd_write;
  logic [1:0]                 src_sel;
  logic [LOAD_TYPE_WIDTH-1:0] src_ltype;

  logic [DATA_WIDTH-1:0]      load_data, result;

  logic                       rf_en;
  logic [REG_ADDR_WIDTH-1:0]  rf_addr;
  logic [DATA_WIDTH-1:0]      rf_data;

  // While waiting on the cache the captured copy is the instruction of record
  always_comb begin
    if (state == WAIT_LOAD) begin
      src_alu = cap_alu;  src_pc4 = cap_pc4;  src_csr = cap_csr;
      src_rd = cap_rd;    src_rd_write = cap_rd_write;
      src_sel = cap_sel;  src_ltype = cap_ltype;
    end else begin
      src_alu = bus.mem_alu_out_in;  src_pc4 = bus.mem_pc_plus4_in;
      src_csr = bus.mem_csr_data_in; src_rd = bus.mem_rd_addr_in;
      src_rd_write = bus.mem_rd_write_in;
      src_sel = bus.mem_wb_select_in; src_ltype = bus.mem_load_type_in;
    end
  end

  load_data_aligner #(
    .DATA_WIDTH      (DATA_WIDTH),
    .LOAD_TYPE_WIDTH (LOAD_TYPE_WIDTH)
  ) u_align (
    .raw_data  (bus.data_cache_out_data),
    .addr_lo   (src_alu[OFF_W-1:0]),
    .load_type (src_ltype),
    .ext_data  (load_data)
  );

  // Four-way result source select
  always_comb begin
    result = src_alu;
    case (src_sel)
      WB_SEL_ALU:  result = src_alu;
      WB_SEL_LOAD: result = load_data;
      WB_SEL_PC4:  result = src_pc4;
      WB_SEL_CSR:  result = src_csr;
      default:     result = src_alu;
    endcase
  end

  // Next-state, stall and retire decisions; flush beats cache ready
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    retire     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_valid_in && !bus.flush_in) begin
          if (bus.mem_wb_select_in == WB_SEL_LOAD && !bus.data_cache_ready) begin
            capture    = 1'b1;
            stall      = 1'b1;
            state_next = WAIT_LOAD;
          end else begin
            retire = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (bus.flush_in) begin
          state_next = IDLE;
        end else if (bus.data_cache_ready) begin
          retire     = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Snapshot of the MEM instruction when a load misses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_alu <= '0; cap_pc4 <= '0; cap_csr <= '0; cap_rd <= '0;
      cap_rd_write <= 1'b0; cap_sel <= '0; cap_ltype <= '0;
    end else if (capture) begin
      cap_alu      <= bus.mem_alu_out_in;
      cap_pc4      <= bus.mem_pc_plus4_in;
      cap_csr      <= bus.mem_csr_data_in;
      cap_rd       <= bus.mem_rd_addr_in;
      cap_rd_write <= bus.mem_rd_write_in;
      cap_sel      <= bus.mem_wb_select_in;
      cap_ltype    <= bus.mem_load_type_in;
    end
  end

  // Register-file write port; strobe pulses once, data holds between retirements
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_en   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_en <= retire && src_rd_write && (src_rd != '0);
      if (retire) begin
        rf_addr <= src_rd;
        rf_data <= result;
      end
    end
  end

  assign bus.wb_stall_out      = stall & rst_n;
  assign bus.rf_write_en_out   = rf_en;
  assign bus.rf_write_addr_out = rf_addr;
  assign bus.rf_write_data_out = rf_data;

endmodule
`default_nettype wire

// File: tb/tb_write_back_pipeline.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_write_back_pipeline                                 |
// | Purpose : Scoreboard bench for write_back_pipeline (32-bit main  |
// |           instance, 64-bit instance for wide word alignment).    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_write_back_pipeline;
  import riscv_wb_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [4:0]  q_addr[$];
  logic [31:0] q_data[$];

  localparam logic [31:0] PC4_VAL = 32'h0000_0104;
  localparam logic [31:0] CSR_VAL = 32'hC5C5_0001;

  write_back_pipeline_if #(.DATA_WIDTH(32)) bus32 ();
  write_back_pipeline_if #(.DATA_WIDTH(64)) bus64 ();

  write_back_pipeline #(.DATA_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  write_back_pipeline #(.DATA_WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic v, input logic [1:0] sel, input logic [2:0] lt,
                         input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                         input logic [31:0] word, input logic rdy, input logic fl);
    bus32.mem_valid_in        = v;
    bus32.mem_wb_select_in    = sel;
    bus32.mem_load_type_in    = lt;
    bus32.mem_rd_addr_in      = rd;
    bus32.mem_rd_write_in     = rw;
    bus32.mem_alu_out_in      = alu;
    bus32.mem_pc_plus4_in     = PC4_VAL;
    bus32.mem_csr_data_in     = CSR_VAL;
    bus32.data_cache_out_data = word;
    bus32.data_cache_ready    = rdy;
    bus32.flush_in            = fl;
  endtask

  task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
    q_addr.push_back(a);
    q_data.push_back(d);
  endtask

  task automatic issue64(input logic [2:0] lt, input logic [63:0] alu, input logic [63:0] word);
    bus64.mem_valid_in        = 1'b1;
    bus64.mem_wb_select_in    = WB_SEL_LOAD;
    bus64.mem_load_type_in    = lt;
    bus64.mem_rd_addr_in      = 5'd3;
    bus64.mem_rd_write_in     = 1'b1;
    bus64.mem_alu_out_in      = alu;
    bus64.mem_pc_plus4_in     = '0;
    bus64.mem_csr_data_in     = '0;
    bus64.data_cache_out_data = word;
    bus64.data_cache_ready    = 1'b1;
    bus64.flush_in            = 1'b0;
  endtask

  // Monitor: every write strobe must match the oldest expected retirement
  initial begin
    logic [4:0]  ea;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      if (rst_n && bus32.rf_write_en_out) begin
        if (q_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_en: got addr %0d data %h, required no write",
                   bus32.rf_write_addr_out, bus32.rf_write_data_out);
        end else begin
          ea = q_addr.pop_front();
          ed = q_data.pop_front();
          check("wb_addr", 64'(bus32.rf_write_addr_out), 64'(ea));
          check("wb_data", 64'(bus32.rf_write_data_out), 64'(ed));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    issue32(0, WB_SEL_ALU, LOAD_LW, 0, 0, 0, 0, 0, 0);
    issue64(LOAD_LW, 0, 0);
    bus64.mem_valid_in = 1'b0;
    #12;
    check("reset_en",    64'(bus32.rf_write_en_out),   64'd0);
    check("reset_addr",  64'(bus32.rf_write_addr_out), 64'd0);
    check("reset_data",  64'(bus32.rf_write_data_out), 64'd0);
    check("reset_stall", 64'(bus32.wb_stall_out),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // ALU result, 1-cycle latency, single pulse
    issue32(1, WB_SEL_ALU, LOAD_LW, 5, 1, 32'h0000_1234, 0, 0, 0);
    expect_wb(5, 32'h0000_1234);
    cyc();
    issue32(0, WB_SEL_ALU, LOAD_LW, 0, 0, 0, 0, 0, 0);
    cyc();
    check("alu_en_drop", 64'(bus32.rf_write_en_out), 64'd0);

    // PC+4 and CSR sources
    issue32(1, WB_SEL_PC4, LOAD_LW, 1, 1, 32'hDEAD_0000, 0, 0, 0);
    expect_wb(1, PC4_VAL);
    cyc();
    issue32(1, WB_SEL_CSR, LOAD_LW, 2, 1, 32'hDEAD_0000, 0, 0, 0);
    expect_wb(2, CSR_VAL);
    cyc();

    // Byte and half loads with lane selection and extension
    issue32(1, WB_SEL_LOAD, LOAD_LB, 6, 1, 32'h0000_1003, 32'h80FF_0000, 1, 0);
    expect_wb(6, 32'hFFFF_FF80);
    cyc();
    issue32(1, WB_SEL_LOAD, LOAD_LBU, 7, 1, 32'h0000_1003, 32'h80FF_0000, 1, 0);
    expect_wb(7, 32'h0000_0080);
    cyc();
    issue32(1, WB_SEL_LOAD, LOAD_LH, 6, 1, 32'h0000_1002, 32'h8001_7FFF, 1, 0);
    expect_wb(6, 32'hFFFF_8001);
    cyc();
    issue32(1, WB_SEL_LOAD, LOAD_LHU, 7, 1, 32'h0000_1003, 32'h8001_7FFF, 1, 0);
    expect_wb(7, 32'h0000_8001);
    cyc();

    // Load miss: three stall cycles with changing MEM inputs, then data
    issue32(1, WB_SEL_LOAD, LOAD_LW, 8, 1, 32'h0000_0100, 32'hBAD0_BAD0, 0, 0);
    expect_wb(8, 32'h1234_5678);
    #1 check("miss_stall_0", 64'(bus32.wb_stall_out), 64'd1);
    cyc();
    check("miss_en_0", 64'(bus32.rf_write_en_out), 64'd0);
    for (int i = 1; i < 3; i++) begin
      issue32(1, WB_SEL_ALU, LOAD_LB, 9, 1, 32'h0000_0F00 + i, 32'hBAD0_BAD0, 0, 0);
      #1 check($sformatf("miss_stall_%0d", i), 64'(bus32.wb_stall_out), 64'd1);
      cyc();
    end
    issue32(1, WB_SEL_ALU, LOAD_LB, 9, 1, 32'h0000_0F03, 32'h1234_5678, 1, 0);
    #1 check("miss_ready_stall", 64'(bus32.wb_stall_out), 64'd0);
    cyc();
    issue32(0, WB_SEL_ALU, LOAD_LW, 0, 0, 0, 0, 0, 0);
    cyc();

    // Flush while waiting, with ready in the same cycle
    issue32(1, WB_SEL_LOAD, LOAD_LW, 10, 1, 32'h0000_0200, 0, 0, 0);
    cyc();
    issue32(0, WB_SEL_ALU, LOAD_LW, 0, 0, 0, 32'hFACE_FACE, 1, 1);
    #1 check("flush_stall", 64'(bus32.wb_stall_out), 64'd0);
    cyc();
    issue32(0, WB_SEL_ALU, LOAD_LW, 0, 0, 0, 0, 0, 0);
    cyc();
    check("flush_en", 64'(bus32.rf_write_en_out), 64'd0);
    issue32(1, WB_SEL_ALU, LOAD_LW, 11, 1, 32'h0000_ABCD, 0, 0, 0);
    expect_wb(11, 32'h0000_ABCD);
    cyc();

    // x0 write: strobe suppressed, data still updates, then holds while idle
    issue32(1, WB_SEL_ALU, LOAD_LW, 0, 1, 32'h0000_0055, 0, 0, 0);
    cyc();
    check("x0_en",   64'(bus32.rf_write_en_out),   64'd0);
    check("x0_data", 64'(bus32.rf_write_data_out), 64'h55);
    issue32(0, WB_SEL_ALU, LOAD_LW, 0, 0, 32'h0000_9999, 0, 0, 0);
    cyc();
    check("idle_hold_data", 64'(bus32.rf_write_data_out), 64'h55);

    // Asynchronous reset while waiting on a load
    issue32(1, WB_SEL_LOAD, LOAD_LW, 12, 1, 32'h0000_0300, 0, 0, 0);
    cyc();
    check("wait_stall", 64'(bus32.wb_stall_out), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_en",    64'(bus32.rf_write_en_out),   64'd0);
    check("arst_addr",  64'(bus32.rf_write_addr_out), 64'd0);
    check("arst_data",  64'(bus32.rf_write_data_out), 64'd0);
    check("arst_stall", 64'(bus32.wb_stall_out),      64'd0);
    issue32(0, WB_SEL_ALU, LOAD_LW, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    issue32(1, WB_SEL_ALU, LOAD_LW, 13, 1, 32'h0000_0077, 0, 0, 0);
    expect_wb(13, 32'h0000_0077);
    cyc();
    issue32(0, WB_SEL_ALU, LOAD_LW, 0, 0, 0, 0, 0, 0);

    // 64-bit word/byte alignment
    issue64(LOAD_LW, 64'h0000_0000_0000_1004, 64'h8000_0000_0000_0000);
    cyc();
    check("w64_lw_en",   64'(bus64.rf_write_en_out), 64'd1);
    check("w64_lw_data", bus64.rf_write_data_out,    64'hFFFF_FFFF_8000_0000);
    issue64(LOAD_LWU, 64'h0000_0000_0000_1004, 64'h8000_0000_0000_0000);
    cyc();
    check("w64_lwu_data", bus64.rf_write_data_out, 64'h0000_0000_8000_0000);
    issue64(LOAD_LD, 64'h0000_0000_0000_1004, 64'h8000_0000_1234_5678);
    cyc();
    check("w64_ld_data", bus64.rf_write_data_out, 64'h8000_0000_1234_5678);
    issue64(LOAD_LB, 64'h0000_0000_0000_1005, 64'h0000_8000_0000_0000);
    cyc();
    check("w64_lb_data", bus64.rf_write_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    bus64.mem_valid_in = 1'b0;
    cyc();
    check("w64_en_drop", 64'(bus64.rf_write_en_out), 64'd0);

    cyc();
    cyc();
    check("scoreboard_drain", 64'(q_addr.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
